// File: rtl/cache_pkg.sv
// Purpose : shared types and constants for the cache miss-fill controller.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
package cache_pkg;

  // Block geometry: 16-byte block, 2-byte words, 8 words per block.
  localparam int BLOCK_OFFSET_W  = 4;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int WORD_BYTES      = 2;

  // Word counters must hold 0..WORDS_PER_BLOCK inclusive.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } fill_state_e;

  // Byte offset of a word inside the block. Because words are 2 bytes wide,
  // the word index is shifted left by one; the result never carries into
  // the index field of the address.
  function automatic logic [BLOCK_OFFSET_W-1:0] word_offset(
    input logic [BLOCK_OFFSET_W-2:0] word_idx
  );
    return {word_idx, 1'b0};
  endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Purpose : 4-bit saturating word counter (0..8) with clear, enable and done.
// Latency : count updates on the clock edge after en_i; done_o is registered state.
// Backpressure: none; en_i is ignored once the counter saturates at 8.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr_i       synchronous clear to 0 (wins over en_i)
//   en_i        count one word
//   idx_o       current word index (low 3 bits of the count)
//   done_o      count has reached WORDS_PER_BLOCK
module fill_word_counter
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [CNT_W-2:0]  idx_o,
  output logic              done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign done_o = (cnt_q == CNT_W'(WORDS_PER_BLOCK));
  assign idx_o  = cnt_q[CNT_W-2:0];

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !done_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cache_fill_controller.sv
// Purpose : on a cache miss, fetch the 8-word block from pipelined memory,
//           stream each word into the data array, then write the tag once.
// Latency : requests start the cycle after the miss edge, one per cycle for 8 cycles;
//           each returned word is written in the same cycle; tag write the cycle after word 8.
// Backpressure: none toward memory; gaps in returns are tolerated indefinitely,
//               and fsm_busy stalls the pipeline for the whole fill.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   miss_detected       cache missed this cycle (sampled only in IDLE)
//   miss_address        address that missed
//   fsm_busy            fill in progress (OR'd into pipeline stall)
//   mem_en, mem_addr    memory read request strobe and address
//   memory_data_valid   memory return strobe
//   memory_data         memory return word
//   write_data_array    cache data-array write strobe
//   write_tag_array     cache tag/valid write strobe
//   cache_addr          address presented to the cache
//   cache_data          word presented to the cache
module cache_fill_controller
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  output logic              fsm_busy,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              memory_data_valid,
  input  logic [DATA_W-1:0] memory_data,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_data
);

  localparam int BLK_W = ADDR_W - BLOCK_OFFSET_W;

  fill_state_e       state_q;
  fill_state_e       state_d;
  logic [ADDR_W-1:0] miss_q;
  logic [ADDR_W-1:0] miss_d;
  // Only the block-number bits of the base are stored; the offset is
  // always zero for a block-aligned base.
  logic [BLK_W-1:0]  blk_q;
  logic [BLK_W-1:0]  blk_d;

  logic              cnt_clr;
  logic              issue_en;
  logic              rcv_en;
  logic [CNT_W-2:0]  issue_idx;
  logic [CNT_W-2:0]  rcv_idx;
  logic              issue_done;
  logic              rcv_done;

  // Counters restart on the same edge that captures a new miss.
  assign cnt_clr  = (state_q == IDLE) && miss_detected;
  assign issue_en = (state_q == FILL) && !issue_done;
  // Returns after the 8th word (or outside FILL) are dropped here.
  assign rcv_en   = (state_q == FILL) && memory_data_valid && !rcv_done;

  fill_word_counter u_issue_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .en_i   (issue_en),
    .idx_o  (issue_idx),
    .done_o (issue_done)
  );

  fill_word_counter u_rcv_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .en_i   (rcv_en),
    .idx_o  (rcv_idx),
    .done_o (rcv_done)
  );

  // Request address tracks the issue counter; mem_en qualifies it.
  assign mem_addr = {blk_q, word_offset(issue_idx)};

  always_comb begin
    state_d          = state_q;
    miss_d           = miss_q;
    blk_d            = blk_q;
    fsm_busy         = 1'b0;
    mem_en           = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    cache_addr       = miss_address;
    cache_data       = '0;

    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          miss_d  = miss_address;
          blk_d   = miss_address[ADDR_W-1:BLOCK_OFFSET_W];
          state_d = FILL;
        end
      end

      FILL: begin
        fsm_busy   = 1'b1;
        mem_en     = issue_en;
        cache_addr = {blk_q, word_offset(rcv_idx)};
        if (rcv_en) begin
          write_data_array = 1'b1;
          cache_data       = memory_data;
          // Leaving on the edge that accepts the last word puts TAG in the
          // very next cycle.
          if (rcv_idx == (CNT_W-1)'(WORDS_PER_BLOCK - 1)) begin
            state_d = TAG;
          end
        end
      end

      TAG: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        // Full miss address so the cache decodes both index and tag.
        cache_addr      = miss_q;
        state_d         = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      miss_q  <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      blk_q   <= blk_d;
    end
  end

endmodule

// File: tb/tb_cache_fill_controller.sv
module tb_cache_fill_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] cache_addr;
  logic [15:0] cache_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Outstanding memory requests of the behavioural memory: address and the
  // cycle (relative to the miss edge) at which the word may be returned.
  logic [15:0] rq_addr[$];
  int          rq_due[$];

  always #5 clk = ~clk;

  cache_fill_controller #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .mem_en            (mem_en),
    .mem_addr          (mem_addr),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .cache_addr        (cache_addr),
    .cache_data        (cache_data)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Memory contents: word index for the sequential pattern, otherwise a
  // scramble of the address so misordered returns are visible.
  function automatic logic [15:0] mem_word(input logic [15:0] a, input bit seq);
    if (seq) return {13'd0, a[3:1]};
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // One complete miss: called at posedge+1 of an IDLE cycle, returns at
  // posedge+1 of the IDLE cycle that follows the fill.
  // gap_mode: 0 no bubbles, 1 two idle cycles after each return, 2 random.
  task automatic run_fill(input logic [15:0] addr, input int lat, input int gap_mode,
                          input bit hold, input bit extra, input bit rst4, input bit seq);
    logic [15:0] base;
    logic [15:0] dv;
    int          n_wr;
    int          tag_c;
    int          gap;
    bit          drove_ret;
    bit          done;
    base  = addr & 16'hFFF0;
    n_wr  = 0;
    tag_c = -1;
    gap   = 0;
    done  = 1'b0;
    rq_addr.delete();
    rq_due.delete();

    // Idle cycle: miss presented, stray memory return must be ignored.
    miss_detected     = 1'b1;
    miss_address      = addr;
    memory_data_valid = 1'b1;
    memory_data       = 16'($urandom);
    #2;
    chk("idle_busy", 32'(fsm_busy), 32'd0);
    chk("idle_mem_en", 32'(mem_en), 32'd0);
    chk("idle_wr_data", 32'(write_data_array), 32'd0);
    chk("idle_wr_tag", 32'(write_tag_array), 32'd0);
    chk("idle_cache_addr", 32'(cache_addr), 32'(addr));
    chk("idle_cache_data", 32'(cache_data), 32'd0);

    for (int c = 1; c <= 200 && !done; c++) begin
      @(posedge clk);
      #1;
      miss_detected = hold;
      if (hold) miss_address = 16'($urandom);
      drove_ret         = 1'b0;
      memory_data_valid = 1'b0;
      memory_data       = 16'($urandom);
      if (rq_addr.size() > 0 && rq_due[0] <= c && gap == 0) begin
        memory_data_valid = 1'b1;
        memory_data       = mem_word(rq_addr[0], seq);
        void'(rq_addr.pop_front());
        void'(rq_due.pop_front());
        drove_ret = 1'b1;
        gap = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      end else begin
        if (gap > 0) gap--;
        if (extra && n_wr >= 8) memory_data_valid = 1'b1;
      end
      dv = memory_data;

      if (rst4 && drove_ret && n_wr == 3) begin
        rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(fsm_busy), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_wr_data", 32'(write_data_array), 32'd0);
        chk("rst_wr_tag", 32'(write_tag_array), 32'd0);
        memory_data_valid = 1'b0;
        miss_detected     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk);
          #3;
          chk("post_rst_busy", 32'(fsm_busy), 32'd0);
          chk("post_rst_wr_tag", 32'(write_tag_array), 32'd0);
        end
        @(posedge clk);
        #1;
        return;
      end

      #2;
      chk("fill_busy", 32'(fsm_busy), 32'd1);
      chk("mem_en", 32'(mem_en), 32'(c <= 8));
      if (c <= 8) begin
        chk("mem_addr", 32'(mem_addr), 32'(base + 16'(2 * (c - 1))));
        rq_addr.push_back(base + 16'(2 * (c - 1)));
        rq_due.push_back(c + lat);
      end
      chk("wr_data", 32'(write_data_array), 32'(drove_ret));
      if (drove_ret) begin
        chk("wr_addr", 32'(cache_addr), 32'(base + 16'(2 * n_wr)));
        chk("wr_word", 32'(cache_data), 32'(dv));
        n_wr++;
        if (n_wr == 8) tag_c = c + 1;
      end
      chk("wr_tag", 32'(write_tag_array), 32'(c == tag_c));
      if (c == tag_c) begin
        chk("tag_addr", 32'(cache_addr), 32'(addr));
        done = 1'b1;
      end
    end
    chk("fill_completed", 32'(done), 32'd1);

    @(posedge clk);
    #1;
    miss_detected     = 1'b0;
    memory_data_valid = 1'b0;
  endtask

  initial begin
    rst_n             = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = 16'h0;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0;
    repeat (2) @(posedge clk);
    #3;
    chk("reset_busy", 32'(fsm_busy), 32'd0);
    chk("reset_mem_en", 32'(mem_en), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_wr_data", 32'(write_data_array), 32'd0);
    chk("reset_wr_tag", 32'(write_tag_array), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed scenarios.
    run_fill(16'h1234, 4, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_fill(16'hFFFE, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_fill(16'h0A5C, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_fill(16'h3344, 5, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_fill(16'h7777, 3, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_fill(16'h5432, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_fill(16'h1234, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_fill(16'h1A34, 6, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized fills: address, latency, bubbles, held miss, extra returns.
    for (int i = 0; i < 20; i++) begin
      run_fill(16'($urandom), int'($urandom_range(1, 6)), 2,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    #2;
    chk("final_idle_busy", 32'(fsm_busy), 32'd0);
    chk("final_idle_wr_tag", 32'(write_tag_array), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
